// File: rtl/id_ex_pipe_v_pkg.sv
// Shared decode constants and bundle sizing for the ID/EX pipeline register.
`default_nettype none

package id_ex_pipe_v_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_IMM  = 7'b0010011;
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;

  // op + funct3 + funct7 + rd, and the three decoded control flags
  localparam int CTRL_W = 7 + 3 + 7 + 5;
  localparam int FLAG_W = 3;

  function automatic int bundle_w(input int data_w);
    return CTRL_W + 3 * data_w + FLAG_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_v_pipe_entry.sv
// Single pipeline entry: payload plus valid bit, with load, clear and async reset.
`default_nettype none

module pipe_entry_v #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Clearing zeroes the payload so an empty entry never shows stale fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_v.sv
// Decode-to-execute pipeline register: two-entry skid buffer with flag decode,
// flush and a saturating stall counter.
`default_nettype none

module id_ex_pipe_v
  import id_ex_pipe_v_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [DATA_W-1:0] in_s_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_op,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [DATA_W-1:0] out_s_data,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = bundle_w(DATA_W);

  function automatic logic [2:0] decode_flags(input logic [6:0] op, input logic [4:0] rd);
    logic rw;
    rw = ((op == R_TYPE) || (op == I_IMM) || (op == I_LOAD)) && (rd != 5'd0);
    return {rw, (op == I_LOAD), (op == S_TYPE)};
  endfunction

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_d;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          main_load;
  logic          main_clear;
  logic          skid_load;
  logic          skid_clear;
  logic          accept;
  logic          consume;

  assign in_bundle = {in_op, in_funct3, in_funct7, in_rd,
                      in_operand1, in_operand2, in_s_data,
                      decode_flags(in_op, in_rd)};

  // skid_valid is a flop, so in_ready never depends on out_ready combinationally
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid & out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_bundle;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || consume) begin
      // Skid always drains before anything newer so ordering stays FIFO.
      if (skid_valid) begin
        main_load  = 1'b1;
        main_d     = skid_q;
        skid_clear = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else if (main_valid) begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  pipe_entry_v #(.W(BW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_entry_v #(.W(BW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_bundle),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign out_valid = main_valid;
  assign {out_op, out_funct3, out_funct7, out_rd,
          out_operand1, out_operand2, out_s_data,
          out_reg_write, out_mem_read, out_mem_write} = main_q;

  // Survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_v.sv
// Directed plus randomized bench for id_ex_pipe_v against a queue-based FIFO model.
`default_nettype none

module tb_id_ex_pipe_v;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_XX = 7'b1111111;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_op;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [DATA_W-1:0] in_operand1;
  logic [DATA_W-1:0] in_operand2;
  logic [DATA_W-1:0] in_s_data;
  logic              out_valid;
  logic              out_ready;
  logic [6:0]        out_op;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_operand1;
  logic [DATA_W-1:0] out_operand2;
  logic [DATA_W-1:0] out_s_data;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [6:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [4:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] s;
    logic              rw;
    logic              mr;
    logic              mw;
  } item_t;

  item_t            q[$];
  logic [CNT_W-1:0] exp_stall;
  int               total  = 0;
  int               passed = 0;
  int               failed = 0;

  id_ex_pipe_v #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_funct3     (in_funct3),
    .in_funct7     (in_funct7),
    .in_rd         (in_rd),
    .in_operand1   (in_operand1),
    .in_operand2   (in_operand2),
    .in_s_data     (in_s_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_rd        (out_rd),
    .out_operand1  (out_operand1),
    .out_operand2  (out_operand2),
    .out_s_data    (out_s_data),
    .out_reg_write (out_reg_write),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic item_t make_item();
    item_t it;
    it.op = in_op;  it.f3 = in_funct3; it.f7 = in_funct7; it.rd = in_rd;
    it.a  = in_operand1; it.b = in_operand2; it.s = in_s_data;
    it.rw = (in_op == OP_R || in_op == OP_I || in_op == OP_LD) && (in_rd != 5'd0);
    it.mr = (in_op == OP_LD);
    it.mw = (in_op == OP_ST);
    return it;
  endfunction

  function automatic item_t dut_item();
    item_t it;
    it = {out_op, out_funct3, out_funct7, out_rd, out_operand1, out_operand2,
          out_s_data, out_reg_write, out_mem_read, out_mem_write};
    return it;
  endfunction

  function automatic item_t exp_item();
    item_t it;
    it = '0;
    if (q.size() != 0) it = q[0];
    return it;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 128'(out_valid), 128'(q.size() != 0));
    check({tag, "_ready"}, 128'(in_ready), 128'(q.size() < 2));
    check({tag, "_fields"}, 128'(dut_item()), 128'(exp_item()));
    check({tag, "_stall"}, 128'(stall_cnt), 128'(exp_stall));
  endtask

  task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    in_valid = v; in_op = op; in_rd = rd; in_operand1 = a; in_operand2 = b; in_s_data = s;
    in_funct3 = 3'(a); in_funct7 = 7'(b);
  endtask

  // Reference behaviour of one rising edge: a two-deep FIFO with flush.
  task automatic model_edge();
    bit acc;
    bit cons;
    if (q.size() != 0 && !out_ready && exp_stall != {CNT_W{1'b1}}) exp_stall++;
    if (flush) begin
      q.delete();
    end else begin
      acc  = in_valid && (q.size() < 2);
      cons = (q.size() != 0) && out_ready;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(make_item());
    end
  endtask

  task automatic cycle(input bit do_check, input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_check) check_model(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    q.delete();
    exp_stall = '0;
    repeat (2) @(negedge clk);
    check_model("reset");
    rst = 1'b0;
    cycle(1'b1, "post_reset");

    // Streaming at full rate
    out_ready = 1'b1;
    set_in(1'b1, OP_R, 5'd5, 32'd3, 32'd4, 32'd0);
    cycle(1'b1, "add");
    check("add_op1", 128'(out_operand1), 128'(32'd3));
    check("add_op2", 128'(out_operand2), 128'(32'd4));
    check("add_rw", 128'(out_reg_write), 128'(1'b1));
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, OP_I, 5'(i + 1), 32'(i + 10), 32'(i + 20), 32'd0);
      cycle(1'b1, "stream");
      check("stream_op1", 128'(out_operand1), 128'(i + 10));
    end
    check("stream_stall", 128'(stall_cnt), 128'(16'd0));
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle(1'b1, "drain");

    // Back-pressure: load then store, skid fills
    out_ready = 1'b0;
    set_in(1'b1, OP_LD, 5'd2, 32'h100, 32'h8, 32'd0);
    cycle(1'b1, "bp_load");
    set_in(1'b1, OP_ST, 5'd0, 32'h200, 32'h4, 32'hDEADBEEF);
    cycle(1'b1, "bp_store");
    check("bp_in_ready", 128'(in_ready), 128'(1'b0));
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check("bp_head_mr", 128'(out_mem_read), 128'(1'b1));
    out_ready = 1'b1;
    cycle(1'b1, "bp_rel1");
    check("bp_second_mw", 128'(out_mem_write), 128'(1'b1));
    check("bp_second_sd", 128'(out_s_data), 128'(32'hDEADBEEF));
    cycle(1'b1, "bp_rel2");

    // Flush while both entries are full and a new instruction is offered
    out_ready = 1'b0;
    set_in(1'b1, OP_R, 5'd7, 32'h11, 32'h22, 32'h0);
    cycle(1'b1, "fl_fill1");
    set_in(1'b1, OP_R, 5'd8, 32'h33, 32'h44, 32'h0);
    cycle(1'b1, "fl_fill2");
    set_in(1'b1, OP_I, 5'd9, 32'h55, 32'h66, 32'h77);
    flush = 1'b1;
    cycle(1'b1, "flush");
    check("flush_valid", 128'(out_valid), 128'(1'b0));
    check("flush_ready", 128'(in_ready), 128'(1'b1));
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle(1'b1, "post_flush");

    // rd=0 suppression and unknown opcode passthrough
    set_in(1'b1, OP_R, 5'd0, 32'h1, 32'h2, 32'h3);
    cycle(1'b1, "rd0");
    check("rd0_rw", 128'(out_reg_write), 128'(1'b0));
    set_in(1'b1, OP_XX, 5'd3, 32'h4, 32'h5, 32'h6);
    cycle(1'b1, "unk");
    check("unk_op", 128'(out_op), 128'(OP_XX));
    check("unk_flags", 128'({out_reg_write, out_mem_read, out_mem_write}), 128'(3'b000));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        default: op = OP_XX;
      endcase
      set_in($urandom_range(0, 3) != 0, op, 5'($urandom), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle(1'b1, "rand");
    end
    flush = 1'b0;

    // Stall counter saturation
    out_ready = 1'b1;
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) cycle(1'b1, "pre_stall");
    set_in(1'b1, OP_R, 5'd1, 32'hA, 32'hB, 32'hC);
    out_ready = 1'b0;
    cycle(1'b1, "stall_load");
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 70000; i++) cycle(1'b0, "stall");
    check_model("stall_sat");
    check("stall_ffff", 128'(stall_cnt), 128'(16'hFFFF));
    cycle(1'b1, "stall_hold");
    check("stall_hold_ffff", 128'(stall_cnt), 128'(16'hFFFF));

    // Async reset with skid full, asserted between edges
    set_in(1'b1, OP_ST, 5'd4, 32'h1, 32'h2, 32'h3);
    cycle(1'b1, "ar_fill");
    check("ar_full", 128'(in_ready), 128'(1'b0));
    set_in(1'b0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    model_edge();
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 128'(out_valid), 128'(1'b0));
    check("ar_stall", 128'(stall_cnt), 128'(16'd0));
    check("ar_ready", 128'(in_ready), 128'(1'b1));
    q.delete();
    exp_stall = '0;
    check_model("ar_model");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, "ar_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
